counter_run_ctrl: RTL and testbench

Run-control sequencer for the 8-bit counter (clk/reset/enable → count/overflow). It accepts queued commands over a valid/ready interface: clear, run N cycles, idle N cycles, and run-until-wrap with timeout. It drives the counter's enable and a synchronous clear, and counts observed overflows. It sits between a stimulus or CPU-side command source and the counter instance.

---
 rtl/counter_run_ctrl_pkg.sv | 18 +
 rtl/sat_counter.sv | 22 ++
 rtl/counter_run_ctrl.sv | 114 +++++++++++
 tb/tb_counter_run_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_run_ctrl_pkg.sv
// Shared command encodings and sequencer state type for counter_run_ctrl.
package counter_run_ctrl_pkg;

    localparam logic [1:0] OP_CLEAR       = 2'd0;
    localparam logic [1:0] OP_RUN         = 2'd1;
    localparam logic [1:0] OP_WAIT        = 2'd2;
    localparam logic [1:0] OP_RUN_TO_WRAP = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_WAIT,
        S_WRAP,
        S_DONE
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/counter_run_ctrl.sv
// Run-control sequencer for the 8-bit counter: queued clear/run/wait/run-to-wrap
// commands drive the counter's enable and clear, and observed wraps are tallied.
module counter_run_ctrl
    import counter_run_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W        = 16,
    parameter int unsigned WRAP_W       = 8,
    parameter int unsigned CLEAR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    input  logic              cnt_overflow,
    output logic              cnt_enable,
    output logic              cnt_clear,
    output logic              busy,
    output logic              done,
    output logic              done_timeout,
    output logic              done_aborted,
    output logic [WRAP_W-1:0] wrap_count
);

    localparam logic [LEN_W-1:0] CLEAR_LEN = LEN_W'(CLEAR_CYCLES);
    localparam logic [LEN_W-1:0] LAST      = LEN_W'(1);

    state_t           state;
    logic [LEN_W-1:0] rem;
    logic             accept;
    logic             wrap_hit;
    logic             wrap_clr;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign wrap_hit  = cnt_overflow && cnt_enable;
    assign wrap_clr  = accept && (cmd_op == OP_CLEAR);

    sat_counter #(
        .W(WRAP_W)
    ) u_wrap_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (wrap_clr),
        .inc  (wrap_hit),
        .count(wrap_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            rem          <= '0;
            cnt_enable   <= 1'b0;
            cnt_clear    <= 1'b0;
            done         <= 1'b0;
            done_timeout <= 1'b0;
            done_aborted <= 1'b0;
        end else begin
            done         <= 1'b0;
            done_timeout <= 1'b0;
            done_aborted <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (cmd_op == OP_CLEAR) begin
                            state     <= S_CLEAR;
                            rem       <= CLEAR_LEN;
                            cnt_clear <= 1'b1;
                        end else if (cmd_len == '0) begin
                            state        <= S_DONE;
                            done         <= 1'b1;
                            done_timeout <= (cmd_op == OP_RUN_TO_WRAP);
                        end else begin
                            rem        <= cmd_len;
                            cnt_enable <= (cmd_op != OP_WAIT);
                            case (cmd_op)
                                OP_RUN:  state <= S_RUN;
                                OP_WAIT: state <= S_WAIT;
                                default: state <= S_WRAP;
                            endcase
                        end
                    end
                end
                S_CLEAR, S_RUN, S_WAIT, S_WRAP: begin
                    rem <= rem - 1'b1;
                    // Abort outranks a same-cycle wrap, and a wrap outranks expiry.
                    if (abort) begin
                        state        <= S_DONE;
                        cnt_enable   <= 1'b0;
                        cnt_clear    <= 1'b0;
                        done         <= 1'b1;
                        done_aborted <= 1'b1;
                    end else if ((state == S_WRAP) && wrap_hit) begin
                        state      <= S_DONE;
                        cnt_enable <= 1'b0;
                        done       <= 1'b1;
                    end else if (rem == LAST) begin
                        state        <= S_DONE;
                        cnt_enable   <= 1'b0;
                        cnt_clear    <= 1'b0;
                        done         <= 1'b1;
                        done_timeout <= (state == S_WRAP);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench: counter_run_ctrl driving a behavioural 8-bit counter, plus a
// narrow-wrap instance fed with hand-placed overflow pulses.
module tb_counter_run_ctrl;
    import counter_run_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_len;
    logic        abort;
    logic        cnt_overflow;
    logic        cnt_enable;
    logic        cnt_clear;
    logic        busy;
    logic        done;
    logic        done_timeout;
    logic        done_aborted;
    logic [7:0]  wrap_count;
    logic [7:0]  count;
    logic [6:0]  st;

    logic        c2_valid;
    logic        c2_ready;
    logic [1:0]  c2_op;
    logic [15:0] c2_len;
    logic        c2_abort;
    logic        c2_ovf;
    logic        c2_en;
    logic        c2_clr;
    logic        c2_busy;
    logic        c2_done;
    logic        c2_to;
    logic        c2_ab;
    logic [1:0]  c2_wrap;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    counter_run_ctrl #(
        .LEN_W(16), .WRAP_W(8), .CLEAR_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .abort(abort), .cnt_overflow(cnt_overflow),
        .cnt_enable(cnt_enable), .cnt_clear(cnt_clear), .busy(busy), .done(done),
        .done_timeout(done_timeout), .done_aborted(done_aborted), .wrap_count(wrap_count)
    );

    counter_run_ctrl #(
        .LEN_W(16), .WRAP_W(2), .CLEAR_CYCLES(2)
    ) dut2 (
        .clk(clk), .reset(reset), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
        .cmd_op(c2_op), .cmd_len(c2_len), .abort(c2_abort), .cnt_overflow(c2_ovf),
        .cnt_enable(c2_en), .cnt_clear(c2_clr), .busy(c2_busy), .done(c2_done),
        .done_timeout(c2_to), .done_aborted(c2_ab), .wrap_count(c2_wrap)
    );

    // Attached counter: overflow flags the cycle in which the count sits at its maximum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           count <= '0;
        else if (cnt_clear)  count <= '0;
        else if (cnt_enable) count <= count + 8'd1;
    end
    assign cnt_overflow = (count == 8'hFF);

    assign st = {cmd_ready, busy, cnt_enable, cnt_clear, done, done_timeout, done_aborted};

    task automatic issue(input logic [1:0] op, input logic [15:0] len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (st !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_status: got %b expected %b", st, 7'b1000000);
        end
        n_cmp++;
        if (wrap_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_wrap: got %0d expected 0", wrap_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_run();
        logic [6:0] exp;
        issue(OP_RUN, 16'd5);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            exp = {k == 7, k != 7, k <= 5, 1'b0, k == 6, 1'b0, 1'b0};
            n_cmp++;
            if (st !== exp) begin
                n_err++;
                $display("FAIL run5_cycle%0d: got %b expected %b", k, st, exp);
            end
        end
        n_cmp++;
        if (count !== 8'd5) begin
            n_err++;
            $display("FAIL run5_count: got %0d expected 5", count);
        end
    endtask

    task automatic test_wait();
        logic [6:0] exp;
        issue(OP_WAIT, 16'd3);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp = {k == 5, k != 5, 1'b0, 1'b0, k == 4, 1'b0, 1'b0};
            n_cmp++;
            if (st !== exp) begin
                n_err++;
                $display("FAIL wait3_cycle%0d: got %b expected %b", k, st, exp);
            end
        end
        n_cmp++;
        if (count !== 8'd5) begin
            n_err++;
            $display("FAIL wait3_count: got %0d expected 5", count);
        end
    endtask

    task automatic test_clear();
        logic [6:0] exp;
        issue(OP_CLEAR, 16'd99);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp = {k == 4, k != 4, 1'b0, k <= 2, k == 3, 1'b0, 1'b0};
            n_cmp++;
            if (st !== exp) begin
                n_err++;
                $display("FAIL clear_cycle%0d: got %b expected %b", k, st, exp);
            end
            if (k == 1) begin
                n_cmp++;
                if (wrap_count !== 8'd0) begin
                    n_err++;
                    $display("FAIL clear_wrap: got %0d expected 0", wrap_count);
                end
            end
        end
        n_cmp++;
        if (count !== 8'd0) begin
            n_err++;
            $display("FAIL clear_count: got %0d expected 0", count);
        end
    endtask

    task automatic test_run_to_wrap(input logic [15:0] len, input int exp_en,
                                    input logic exp_to, input logic [7:0] exp_wrap,
                                    input logic [7:0] exp_count);
        int en_cycles = 0;
        int done_k    = 0;
        logic to_seen = 1'b0;
        logic ab_seen = 1'b0;
        issue(OP_RUN_TO_WRAP, len);
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (cnt_enable) en_cycles++;
            if (done) begin
                done_k  = k;
                to_seen = done_timeout;
                ab_seen = done_aborted;
                break;
            end
        end
        n_cmp++;
        if (done_k !== exp_en + 1) begin
            n_err++;
            $display("FAIL wrap%0d_done_cycle: got %0d expected %0d", len, done_k, exp_en + 1);
        end
        n_cmp++;
        if (en_cycles !== exp_en) begin
            n_err++;
            $display("FAIL wrap%0d_enable_cycles: got %0d expected %0d", len, en_cycles, exp_en);
        end
        n_cmp++;
        if ({to_seen, ab_seen} !== {exp_to, 1'b0}) begin
            n_err++;
            $display("FAIL wrap%0d_flags: got %b expected %b", len, {to_seen, ab_seen}, {exp_to, 1'b0});
        end
        n_cmp++;
        if (wrap_count !== exp_wrap) begin
            n_err++;
            $display("FAIL wrap%0d_wrap_count: got %0d expected %0d", len, wrap_count, exp_wrap);
        end
        n_cmp++;
        if (count !== exp_count) begin
            n_err++;
            $display("FAIL wrap%0d_count: got %0d expected %0d", len, count, exp_count);
        end
    endtask

    task automatic test_zero_len();
        issue(OP_RUN, 16'd0);
        @(negedge clk);
        n_cmp++;
        if (st !== 7'b0100100) begin
            n_err++;
            $display("FAIL run0_done: got %b expected %b", st, 7'b0100100);
        end
        @(negedge clk);
        n_cmp++;
        if (st !== 7'b1000000) begin
            n_err++;
            $display("FAIL run0_idle: got %b expected %b", st, 7'b1000000);
        end
        issue(OP_RUN_TO_WRAP, 16'd0);
        @(negedge clk);
        n_cmp++;
        if (st !== 7'b0100110) begin
            n_err++;
            $display("FAIL wrap0_done: got %b expected %b", st, 7'b0100110);
        end
    endtask

    task automatic test_abort();
        issue(OP_RUN, 16'd50);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (st !== 7'b0110000) begin
                n_err++;
                $display("FAIL abort_run_cycle%0d: got %b expected %b", k, st, 7'b0110000);
            end
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (st !== 7'b0100101) begin
            n_err++;
            $display("FAIL abort_done: got %b expected %b", st, 7'b0100101);
        end
        @(negedge clk);
        n_cmp++;
        if (st !== 7'b1000000) begin
            n_err++;
            $display("FAIL abort_idle: got %b expected %b", st, 7'b1000000);
        end
        n_cmp++;
        if (count !== 8'd3) begin
            n_err++;
            $display("FAIL abort_count: got %0d expected 3", count);
        end
    endtask

    task automatic test_abort_on_wrap();
        int hit_k = 0;
        issue(OP_RUN_TO_WRAP, 16'd1000);
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (count == 8'hFF) begin
                hit_k = k;
                break;
            end
        end
        n_cmp++;
        if (hit_k !== 253) begin
            n_err++;
            $display("FAIL abortwrap_reach_ff: got cycle %0d expected 253", hit_k);
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (st !== 7'b0100101) begin
            n_err++;
            $display("FAIL abortwrap_done: got %b expected %b", st, 7'b0100101);
        end
        n_cmp++;
        if (wrap_count !== 8'd1) begin
            n_err++;
            $display("FAIL abortwrap_wrap_count: got %0d expected 1", wrap_count);
        end
    endtask

    task automatic test_reset_mid_run();
        int done_seen = 0;
        issue(OP_RUN, 16'd20);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (st !== 7'b1000000) begin
            n_err++;
            $display("FAIL midreset_status: got %b expected %b", st, 7'b1000000);
        end
        n_cmp++;
        if ({wrap_count, count} !== 16'd0) begin
            n_err++;
            $display("FAIL midreset_counts: got %0d/%0d expected 0/0", wrap_count, count);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        n_cmp++;
        if (done_seen !== 0) begin
            n_err++;
            $display("FAIL midreset_no_done: got %0d done cycles expected 0", done_seen);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        c2_valid = 1'b1;
        c2_op    = OP_RUN;
        c2_len   = 16'd20;
        @(posedge clk);
        #1 c2_valid = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 3 || k == 7 || k == 9 || k == 12) begin
                n_cmp++;
                if (c2_wrap !== ((k == 3) ? 2'd1 : 2'd3)) begin
                    n_err++;
                    $display("FAIL sat_cycle%0d: got %0d expected %0d", k, c2_wrap, (k == 3) ? 1 : 3);
                end
            end
            if (k == 21) begin
                n_cmp++;
                if ({c2_done, c2_en} !== 2'b10) begin
                    n_err++;
                    $display("FAIL sat_done: got %b expected 10", {c2_done, c2_en});
                end
            end
            c2_ovf = (k <= 10) && (k % 2 == 0);
        end
        c2_ovf = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_len   = 16'd0;
        abort     = 1'b0;
        c2_valid  = 1'b0;
        c2_op     = 2'd0;
        c2_len    = 16'd0;
        c2_abort  = 1'b0;
        c2_ovf    = 1'b0;
        test_reset();
        test_run();
        test_wait();
        test_clear();
        test_run_to_wrap(16'd1000, 256, 1'b0, 8'd1, 8'd0);
        test_run_to_wrap(16'd10, 10, 1'b1, 8'd1, 8'd10);
        test_clear();
        test_zero_len();
        test_abort();
        test_abort_on_wrap();
        test_reset_mid_run();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
